// File: rtl/tinycpu_loader_pkg.sv
// Shared definitions for the tinyCPU serial program loader: sync byte, FSM encodings
// and the UART baud divisor helper.
package tinycpu_loader_pkg;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Clocks per UART bit; callers keep CLK_HZ/BAUD >= 16.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, one-clk byte/frame-error pulses.
module uart_rx_byte
  import tinycpu_loader_pkg::*;
#(
  parameter int unsigned DIV = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       uart_rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);

  logic [1:0]       r_sync;
  logic             r_prev;
  logic             w_rx;
  rx_state_t        r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [2:0]       r_bit, w_bit_n;
  logic [7:0]       r_shift, w_shift_n;
  logic [7:0]       w_byte_n;
  logic             w_valid_n, w_ferr_n;

  assign w_rx = r_sync[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync       <= 2'b11;
      r_prev       <= 1'b1;
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      byte_o       <= '0;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], uart_rx_i};
      r_prev       <= w_rx;
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_bit        <= w_bit_n;
      r_shift      <= w_shift_n;
      byte_o       <= w_byte_n;
      byte_valid_o <= w_valid_n;
      frame_err_o  <= w_ferr_n;
    end
  end

  // Start bit is re-checked at half a bit; a short low glitch falls back to idle.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + 1'b1;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_byte_n  = byte_o;
    w_valid_n = 1'b0;
    w_ferr_n  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_n = '0;
        if (r_prev && !w_rx) w_state_n = RX_START;
      end
      RX_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_n   = '0;
          w_bit_n   = '0;
          w_state_n = w_rx ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_n   = '0;
          w_shift_n = {w_rx, r_shift[7:1]};
          w_bit_n   = r_bit + 1'b1;
          if (r_bit == 3'd7) w_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_n   = '0;
          w_state_n = RX_IDLE;
          if (w_rx) begin
            w_valid_n = 1'b1;
            w_byte_n  = r_shift;
          end else begin
            w_ferr_n = 1'b1;
          end
        end
      end
      default: w_state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/imem_uart_loader.sv
// UART instruction-memory loader: frame FSM and little-endian word assembly.
// Optional trailing XOR checksum enabled by `define IMEM_LOADER_CSUM_EN.
module imem_uart_loader
  import tinycpu_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              uart_rx_i,
  input  logic              load_en_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [31:0]       wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [8:0]  DEPTH_LIM = 9'(DEPTH);

  logic [7:0] w_rx_byte;
  logic       w_rx_valid, w_rx_ferr;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk          (clk),
    .rstn         (rstn),
    .uart_rx_i    (uart_rx_i),
    .byte_o       (w_rx_byte),
    .byte_valid_o (w_rx_valid),
    .frame_err_o  (w_rx_ferr)
  );

  loader_state_t     r_state, w_state_n;
  logic [CNT_W-1:0]  r_len, w_len_n;
  logic [CNT_W-1:0]  w_wcnt_n;
  logic [1:0]        r_bidx, w_bidx_n;
  logic [23:0]       r_shift, w_shift_n;
  logic              w_we_n, w_busy_n, w_done_n, w_err_n;
  logic [ADDR_W-1:0] w_waddr_n;
  logic [31:0]       w_wdata_n;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        r_csum, w_csum_n;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_bidx     <= '0;
      r_shift    <= '0;
      we_o       <= 1'b0;
      waddr_o    <= '0;
      wdata_o    <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      word_cnt_o <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_state    <= w_state_n;
      r_len      <= w_len_n;
      r_bidx     <= w_bidx_n;
      r_shift    <= w_shift_n;
      we_o       <= w_we_n;
      waddr_o    <= w_waddr_n;
      wdata_o    <= w_wdata_n;
      busy_o     <= w_busy_n;
      done_o     <= w_done_n;
      err_o      <= w_err_n;
      word_cnt_o <= w_wcnt_n;
`ifdef IMEM_LOADER_CSUM_EN
      r_csum     <= w_csum_n;
`endif
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_len_n   = r_len;
    w_bidx_n  = r_bidx;
    w_shift_n = r_shift;
    w_we_n    = 1'b0;
    w_waddr_n = waddr_o;
    w_wdata_n = wdata_o;
    w_busy_n  = busy_o;
    w_done_n  = done_o;
    w_err_n   = err_o;
    w_wcnt_n  = word_cnt_o;
`ifdef IMEM_LOADER_CSUM_EN
    w_csum_n  = r_csum;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_rx_valid && (w_rx_byte == LOADER_SYNC_BYTE) && load_en_i) begin
          w_state_n = ST_LEN;
          w_busy_n  = 1'b1;
          w_done_n  = 1'b0;
          w_err_n   = 1'b0;
          w_wcnt_n  = '0;
          w_bidx_n  = '0;
`ifdef IMEM_LOADER_CSUM_EN
          w_csum_n  = '0;
`endif
        end
      end
      ST_LEN, ST_DATA, ST_CSUM: begin
        // Abort and framing errors win over any byte arriving in the same cycle.
        if (!load_en_i || w_rx_ferr) begin
          w_state_n = ST_ERR;
        end else if (w_rx_valid) begin
          case (r_state)
            ST_LEN: begin
              if ((w_rx_byte == 8'h00) || ({1'b0, w_rx_byte} > DEPTH_LIM)) begin
                w_state_n = ST_ERR;
              end else begin
                w_len_n   = CNT_W'(w_rx_byte);
                w_state_n = ST_DATA;
              end
            end
            ST_DATA: begin
              w_shift_n = {w_rx_byte, r_shift[23:8]};
              w_bidx_n  = r_bidx + 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
              w_csum_n  = r_csum ^ w_rx_byte;
`endif
              if (r_bidx == 2'd3) begin
                w_we_n    = 1'b1;
                w_waddr_n = word_cnt_o[ADDR_W-1:0];
                w_wdata_n = {w_rx_byte, r_shift};
                w_wcnt_n  = word_cnt_o + 1'b1;
                if (w_wcnt_n == r_len) begin
`ifdef IMEM_LOADER_CSUM_EN
                  w_state_n = ST_CSUM;
`else
                  w_state_n = ST_DONE;
`endif
                end
              end
            end
`ifdef IMEM_LOADER_CSUM_EN
            ST_CSUM: w_state_n = (w_rx_byte == r_csum) ? ST_DONE : ST_ERR;
`endif
            default: w_state_n = ST_ERR;
          endcase
        end
      end
      ST_DONE: begin
        w_done_n  = 1'b1;
        w_err_n   = 1'b0;
        w_busy_n  = 1'b0;
        w_state_n = ST_IDLE;
      end
      ST_ERR: begin
        w_err_n   = 1'b1;
        w_done_n  = 1'b0;
        w_busy_n  = 1'b0;
        w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader; expected IM writes are queued as frames are sent.
module tb_imem_uart_loader;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned CLK_HZ = 1_600_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned DIV    = CLK_HZ / BAUD;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              uart_rx = 1'b1;
  logic              load_en = 1'b1;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              busy, done, err;
  logic [ADDR_W:0]   wcnt;

  int checks = 0;
  int errors = 0;
  int writes = 0;
  int wr_mark;
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] mon_e;
  logic [7:0]         csum;

  always #5 clk = ~clk;

  imem_uart_loader #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .uart_rx_i  (uart_rx),
    .load_en_i  (load_en),
    .we_o       (we),
    .waddr_o    (waddr),
    .wdata_o    (wdata),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .word_cnt_o (wcnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every we_o pulse must match the oldest queued {addr, data}.
  always @(negedge clk) begin
    if (rstn && we) begin
      writes++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_we observed addr=%0h data=%0h expected none", waddr, wdata);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("waddr", 32'(waddr), 32'(mon_e[ADDR_W+31:32]));
        chk("wdata", wdata, mon_e[31:0]);
      end
    end
  end

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_time(input logic v);
    uart_rx = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(!bad_stop);
    if (bad_stop) bit_time(1'b1);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [ADDR_W-1:0] a, input bit expect_wr);
    if (expect_wr) exp_q.push_back({a, w});
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      csum = csum ^ w[8*i +: 8];
    end
  endtask

  task automatic start_frame(input logic [7:0] len);
    csum = 8'h00;
    send_byte(8'hA5);
    send_byte(len);
  endtask

  task automatic end_frame();
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(csum);
`endif
    idle(20);
  endtask

  initial begin
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_wcnt", 32'(wcnt), 0);
    rstn = 1'b1;
    idle(10);

    // Two-word image
    wr_mark = writes;
    csum = 8'h00;
    send_byte(8'hA5);
    idle(8);
    chk("t1_busy_after_sync", 32'(busy), 1);
    send_byte(8'd2);
    send_word(32'h00500093, 6'd0, 1'b1);
    send_word(32'h00A00113, 6'd1, 1'b1);
    end_frame();
    chk("t1_done", 32'(done), 1);
    chk("t1_err", 32'(err), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_wcnt", 32'(wcnt), 2);
    chk("t1_writes", 32'(writes - wr_mark), 2);

    // LEN = 0 and LEN > DEPTH
    wr_mark = writes;
    start_frame(8'd0);
    idle(20);
    chk("t2_err", 32'(err), 1);
    chk("t2_done", 32'(done), 0);
    chk("t2_busy", 32'(busy), 0);
    start_frame(8'd65);
    idle(20);
    chk("t2b_err", 32'(err), 1);
    chk("t2_writes", 32'(writes - wr_mark), 0);

    // Framing error on the 3rd data byte
    wr_mark = writes;
    start_frame(8'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33, 1'b1);
    idle(20);
    chk("t3_err", 32'(err), 1);
    chk("t3_wcnt", 32'(wcnt), 0);
    chk("t3_writes", 32'(writes - wr_mark), 0);

    // Enable dropped after 5 data bytes
    wr_mark = writes;
    start_frame(8'd2);
    send_word(32'hDEADBEEF, 6'd0, 1'b1);
    send_byte(8'h55);
    idle(4);
    load_en = 1'b0;
    idle(20);
    chk("t4_err", 32'(err), 1);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_wcnt", 32'(wcnt), 1);
    chk("t4_writes", 32'(writes - wr_mark), 1);
    load_en = 1'b1;
    idle(10);

`ifdef IMEM_LOADER_CSUM_EN
    // Checksum good, then corrupted
    start_frame(8'd1);
    send_word(32'h12345678, 6'd0, 1'b1);
    send_byte(csum);
    idle(20);
    chk("t5_done", 32'(done), 1);
    chk("t5_err", 32'(err), 0);
    start_frame(8'd1);
    send_word(32'hCAFEF00D, 6'd0, 1'b1);
    send_byte(csum ^ 8'h04);
    idle(20);
    chk("t5b_err", 32'(err), 1);
    chk("t5b_done", 32'(done), 0);
`endif

    // Reset mid-frame
    start_frame(8'd3);
    send_word(32'h0BADF00D, 6'd0, 1'b1);
    send_byte(8'h01);
    rstn = 1'b0;
    idle(3);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_wcnt", 32'(wcnt), 0);
    chk("rstmid_err", 32'(err), 0);
    rstn = 1'b1;
    idle(10);

    // Garbage and a 1-clk glitch in idle, then a valid 3-word frame
    wr_mark = writes;
    send_byte(8'h12);
    send_byte(8'h34);
    uart_rx = 1'b0;
    @(negedge clk);
    idle(40);
    chk("t6_idle_busy", 32'(busy), 0);
    chk("t6_idle_done", 32'(done), 0);
    start_frame(8'd3);
    send_word(32'h00000013, 6'd0, 1'b1);
    send_word(32'hFFFFFFFF, 6'd1, 1'b1);
    send_word(32'hA5A5A5A5, 6'd2, 1'b1);
    end_frame();
    chk("t6_done", 32'(done), 1);
    chk("t6_err", 32'(err), 0);
    chk("t6_wcnt", 32'(wcnt), 3);
    chk("t6_writes", 32'(writes - wr_mark), 3);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
